// File: rtl/dac_2ch_pkg.sv
// ---------------------------------------------------------------------------
// dac_2ch_pkg
// Shared definitions for the two-channel interleaving DAC transmit path:
// sample/code width, idle midscale code and the streaming state encoding.
// ---------------------------------------------------------------------------
package dac_2ch_pkg;

    localparam int               DAC_DW       = 14;
    localparam logic [DAC_DW-1:0] DAC_MIDSCALE = 14'h2000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_RUN   = 2'd2,
        ST_DRAIN = 2'd3
    } dac_state_e;

endpackage

// File: rtl/dac_2ch_pair_fifo.sv
// ---------------------------------------------------------------------------
// dac_pair_fifo
// Two-entry FIFO holding {ch1_code, ch2_code} pairs.
// Ports:
//   aclk, areset   clock / asynchronous active-high reset
//   flush          synchronous clear of all entries
//   push, wdata    write request and pair data (ignored when full)
//   pop            read request (ignored when empty)
//   rdata          head entry
//   full, empty    occupancy flags derived from the registered count
// ---------------------------------------------------------------------------
module dac_pair_fifo #(
    parameter int W = 28
) (
    input  logic         aclk,
    input  logic         areset,
    input  logic         flush,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);

    logic [W-1:0] mem_r [2];
    logic         wptr_r;
    logic         rptr_r;
    logic [1:0]   cnt_r;
    logic         push_ok_s;
    logic         pop_ok_s;

    assign full      = (cnt_r == 2'd2);
    assign empty     = (cnt_r == 2'd0);
    assign push_ok_s = push & ~full;
    assign pop_ok_s  = pop & ~empty;
    assign rdata     = mem_r[rptr_r];

    // Storage, pointers and occupancy count.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            mem_r[0] <= {W{1'b0}};
            mem_r[1] <= {W{1'b0}};
            wptr_r   <= 1'b0;
            rptr_r   <= 1'b0;
            cnt_r    <= 2'd0;
        end else if (flush) begin
            wptr_r   <= 1'b0;
            rptr_r   <= 1'b0;
            cnt_r    <= 2'd0;
        end else begin
            if (push_ok_s) begin
                mem_r[wptr_r] <= wdata;
                wptr_r        <= ~wptr_r;
            end
            if (pop_ok_s) begin
                rptr_r <= ~rptr_r;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   cnt_r <= cnt_r + 2'd1;
                2'b01:   cnt_r <= cnt_r - 2'd1;
                default: cnt_r <= cnt_r;
            endcase
        end
    end

endmodule

// File: rtl/dac_2ch.sv
// ---------------------------------------------------------------------------
// dac_2ch
// Accepts signed sample pairs, converts them to offset-binary codes, buffers
// them in a 2-pair FIFO and time-interleaves ch1/ch2 onto one registered
// DAC bus, one channel per clock.
// Ports:
//   aclk, areset          clock / asynchronous active-high reset
//   enable                start (prime + stream) / stop streaming
//   s_valid, s_ready      input pair handshake
//   s_ch1, s_ch2          signed two's complement samples
//   dac_dat               offset-binary code on the DAC bus
//   dac_sel               1 = dac_dat is ch1, 0 = ch2
//   dac_wrt               write strobe for codes issued while streaming
//   running               high in RUN and DRAIN
//   underrun_cnt          saturating count of pair slots with an empty FIFO
// ---------------------------------------------------------------------------
module dac_2ch
    import dac_2ch_pkg::*;
#(
    parameter int             DW            = DAC_DW,
    parameter logic [DW-1:0]  MIDSCALE      = DAC_MIDSCALE,
    parameter bit             UNDERRUN_HOLD = 1'b1,
    parameter int             CNT_W         = 16
) (
    input  logic             aclk,
    input  logic             areset,
    input  logic             enable,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [DW-1:0]    s_ch1,
    input  logic [DW-1:0]    s_ch2,
    output logic [DW-1:0]    dac_dat,
    output logic             dac_sel,
    output logic             dac_wrt,
    output logic             running,
    output logic [CNT_W-1:0] underrun_cnt
);

    dac_state_e      state_r, state_nxt_s;
    logic            ph_r, ph_nxt_s;
    logic [DW-1:0]   cur1_r, cur2_r;
    logic [DW-1:0]   dat_r, dat_nxt_s;
    logic            sel_r, sel_nxt_s;
    logic            wrt_r, wrt_nxt_s;
    logic [CNT_W-1:0] ucnt_r;

    logic            full_s, empty_s, flush_s;
    logic            push_s, pop_s, under_s;
    logic [2*DW-1:0] wdata_s, rdata_s;

    // Offset binary is two's complement with the sign bit inverted.
    assign wdata_s = {~s_ch1[DW-1], s_ch1[DW-2:0], ~s_ch2[DW-1], s_ch2[DW-2:0]};

    assign s_ready = ((state_r == ST_PRIME) || (state_r == ST_RUN)) && !full_s;
    assign push_s  = s_valid & s_ready;
    assign running = (state_r == ST_RUN) || (state_r == ST_DRAIN);

    assign dac_dat      = dat_r;
    assign dac_sel      = sel_r;
    assign dac_wrt      = wrt_r;
    assign underrun_cnt = ucnt_r;

    dac_pair_fifo #(.W(2*DW)) u_fifo (
        .aclk   (aclk),
        .areset (areset),
        .flush  (flush_s),
        .push   (push_s),
        .wdata  (wdata_s),
        .pop    (pop_s),
        .rdata  (rdata_s),
        .full   (full_s),
        .empty  (empty_s)
    );

    // State register.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic. Stopping on a ch1 slot still owes the ch2 slot (DRAIN);
    // stopping on a ch2 slot completes the pair in that same cycle.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (enable) state_nxt_s = ST_PRIME;
                else        state_nxt_s = ST_IDLE;
            end
            ST_PRIME: begin
                if (!enable)     state_nxt_s = ST_IDLE;
                else if (full_s) state_nxt_s = ST_RUN;
                else             state_nxt_s = ST_PRIME;
            end
            ST_RUN: begin
                if (enable)    state_nxt_s = ST_RUN;
                else if (ph_r) state_nxt_s = ST_IDLE;
                else           state_nxt_s = ST_DRAIN;
            end
            ST_DRAIN: state_nxt_s = ST_IDLE;
            default:  state_nxt_s = ST_IDLE;
        endcase
    end

    // Slot decisions: next bus value, phase, pop / underrun, flush.
    always_comb begin
        dat_nxt_s = MIDSCALE;
        sel_nxt_s = 1'b1;
        wrt_nxt_s = 1'b0;
        ph_nxt_s  = 1'b0;
        pop_s     = 1'b0;
        under_s   = 1'b0;
        flush_s   = 1'b0;
        case (state_r)
            ST_IDLE: flush_s = 1'b1;
            ST_PRIME: begin
                // First pop happens on the PRIME->RUN transition cycle.
                if (enable && full_s) pop_s = 1'b1;
                else                  pop_s = 1'b0;
            end
            ST_RUN: begin
                wrt_nxt_s = 1'b1;
                ph_nxt_s  = ~ph_r;
                if (!ph_r) begin
                    dat_nxt_s = cur1_r;
                    sel_nxt_s = 1'b1;
                end else begin
                    dat_nxt_s = cur2_r;
                    sel_nxt_s = 1'b0;
                    // Pop point; skipped when stopping since the FIFO is flushed anyway.
                    if (!enable)      pop_s   = 1'b0;
                    else if (empty_s) under_s = 1'b1;
                    else              pop_s   = 1'b1;
                end
            end
            ST_DRAIN: begin
                dat_nxt_s = cur2_r;
                sel_nxt_s = 1'b0;
                wrt_nxt_s = 1'b1;
            end
            default: flush_s = 1'b1;
        endcase
    end

    // Registered bus, phase, current pair and underrun counter.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            dat_r  <= MIDSCALE;
            sel_r  <= 1'b1;
            wrt_r  <= 1'b0;
            ph_r   <= 1'b0;
            cur1_r <= MIDSCALE;
            cur2_r <= MIDSCALE;
            ucnt_r <= {CNT_W{1'b0}};
        end else begin
            dat_r <= dat_nxt_s;
            sel_r <= sel_nxt_s;
            wrt_r <= wrt_nxt_s;
            ph_r  <= ph_nxt_s;
            if (pop_s) begin
                cur1_r <= rdata_s[2*DW-1:DW];
                cur2_r <= rdata_s[DW-1:0];
            end else if (under_s && (UNDERRUN_HOLD == 1'b0)) begin
                cur1_r <= MIDSCALE;
                cur2_r <= MIDSCALE;
            end else begin
                cur1_r <= cur1_r;
                cur2_r <= cur2_r;
            end
            if (under_s && (ucnt_r != {CNT_W{1'b1}})) begin
                ucnt_r <= ucnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                ucnt_r <= ucnt_r;
            end
        end
    end

endmodule

// File: doc/dac_2ch.md
Name: dac_2ch

Overview:
- Transmit-side counterpart of the two-channel ADC capture path.
- Accepts paired 14-bit signed samples (ch1, ch2) over a valid/ready handshake into a 2-entry pair FIFO.
- Converts each sample to offset-binary DAC code.
- Time-interleaves the two channels onto one registered 14-bit DAC bus with select and write strobes, one channel per clock.
- Sits between the sample generator / DSP output and the DAC pins.

Parameters:
- DW, 14, sample and DAC code width
- MIDSCALE, 14'h2000, code driven when idle or on underrun in MID mode
- UNDERRUN_HOLD, 1, 1 = repeat last pair on underrun, 0 = drive MIDSCALE
- CNT_W, 16, width of underrun counter

Ports:
- aclk  in  1  clock; all logic rising-edge
- areset  in  1  asynchronous active-high reset
- enable  in  1  level; start/stop streaming
- s_valid  in  1  input pair valid
- s_ready  out  1  input pair accepted when s_valid & s_ready
- s_ch1  in  DW  ch1 sample, signed two's complement
- s_ch2  in  DW  ch2 sample, signed two's complement
- dac_dat  out  DW  interleaved offset-binary DAC code
- dac_sel  out  1  1 = dac_dat carries ch1, 0 = ch2
- dac_wrt  out  1  write strobe, high while a valid code is on dac_dat
- running  out  1  high in RUN and DRAIN
- underrun_cnt  out  CNT_W  saturating count of underrun pair slots

Behaviour:
- Reset (async, areset=1): state=IDLE, FIFO empty, ph=0, dac_dat=MIDSCALE, dac_sel=1, dac_wrt=0, s_ready=0, running=0, underrun_cnt=0, last pair = MIDSCALE/MIDSCALE. Reset mid-stream aborts immediately, with no drain.
- Conversion: code = {~x[DW-1], x[DW-2:0]}. Examples: -8192 -> 0x0000, 0 -> 0x2000, +8191 -> 0x3FFF. Applied on FIFO write; FIFO stores codes.
- FIFO: 2 pair entries. Push = s_valid & s_ready. s_ready = (state==PRIME or RUN) & ~full. A simultaneous push and pop when full is not allowed, because s_ready is derived from registered full.
- Phase bit ph toggles every cycle in RUN/DRAIN, and is forced to 0 in IDLE/PRIME.
  - ph=0: register ch1 code of the current pair, dac_sel=1.
  - ph=1: register ch2 code of the current pair, dac_sel=0.
- All bus outputs are registered, so the bus lags the phase decision by 1 cycle.
- Pair pop happens on the ph=1 cycle. The popped pair becomes current and is driven starting at the next ph=0.
- Underrun: FIFO empty at a pop point in RUN -> underrun_cnt += 1 (saturates at all-ones). The next slot uses the last pair if UNDERRUN_HOLD=1, else MIDSCALE for both channels. dac_wrt stays high.
- State machine:
  - IDLE: bus at MIDSCALE, wrt=0, FIFO flushed. enable=1 -> PRIME.
  - PRIME: accept pairs, bus idle. FIFO full -> RUN, first pop on the transition cycle. enable=0 -> IDLE (flush).
  - RUN: stream. enable=0 while ph=0 -> DRAIN. enable=0 while ph=1 -> IDLE after that cycle; the current pair's ch2 has already been issued.
  - DRAIN: finish the ch2 slot of the current pair, then IDLE. No pop in DRAIN.
- Pair integrity: ch1 and ch2 of one pair are always driven on consecutive cycles, ch1 first. A pair is never split by stop or underrun.
- Latency: first pair in FIFO appears on dac_dat (ch1) 2 cycles after the PRIME->RUN transition cycle.
- dac_wrt=1 exactly in cycles whose registered dac_dat came from RUN/DRAIN slots.
- underrun_cnt is cleared only by reset.

Decomposition:
- Shared package: DW, MIDSCALE, and the state encoding (IDLE, PRIME, RUN, DRAIN as a 2-bit typedef).
- One natural sub-module: dac_pair_fifo (2-entry, 2*DW wide, full/empty flags, flush input).
- Conversion and interleave stay in the top module.

Test Plan:
- Reset mid-RUN with areset pulse -> same cycle dac_dat=0x2000, dac_wrt=0, s_ready=0, underrun_cnt=0.
- enable=1, push pairs (0,-1), (8191,-8192) -> after PRIME fills, dac_dat sequence 0x2000(sel1), 0x1FFF(sel0), 0x3FFF(sel1), 0x0000(sel0), all with wrt=1.
- Sustained s_valid=1 with one pair per 2 cycles -> no underrun over 1000 pairs, underrun_cnt=0, strict ch1/ch2 alternation.
- Stop feeding after 2 pairs, UNDERRUN_HOLD=1 -> last pair repeated, underrun_cnt increments once per pair slot. With UNDERRUN_HOLD=0 -> 0x2000/0x2000.
- Deassert enable on a ph=0 slot -> ch2 of that pair still driven, then wrt=0, dac_dat=0x2000, running=0, FIFO flushed (re-enable requires a fresh PRIME).
- Force 2^CNT_W+5 underruns (CNT_W reduced to 4 in bench) -> underrun_cnt holds at 0xF.
